// File: rtl/iob_2p_mem_rd_stream_pkg.sv
// Shared definitions for the two-port RAM burst read streamer.
// Covers the state encoding, the buffer depth and the credit counter width.
package iob_2p_mem_rd_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int RD_BUF_DEPTH = 3;
  localparam int CREDIT_W     = 2;

endpackage

// File: rtl/iob_2p_mem_rd_buf.sv
// 3-entry register FIFO for returned RAM words. It supports a push and a pop in the same cycle.
// The head register only changes when a new word lands in it, so dout holds its last value when the FIFO drains.
module iob_2p_mem_rd_buf
  import iob_2p_mem_rd_stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic                pop,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   dout,
  output logic                empty,
  output logic [CREDIT_W-1:0] count
);

  logic [DATA_W-1:0]   q [RD_BUF_DEPTH];
  logic                nonempty;
  logic                do_pop;
  logic [CREDIT_W-1:0] count_next;

  assign do_pop     = pop & nonempty;
  assign count_next = count + CREDIT_W'(push) - CREDIT_W'(do_pop);
  assign dout       = q[0];
  assign empty      = ~nonempty;

  // Entries shift toward the head on pop; a simultaneous push lands in the freed tail slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) q[i] <= '0;
      count    <= '0;
      nonempty <= 1'b0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < RD_BUF_DEPTH - 1; i++)
          if (i + 1 < int'(count)) q[i] <= q[i+1];
        if (push) q[count - CREDIT_W'(1)] <= din;
      end else if (push) begin
        q[count] <= din;
      end
      count    <= count_next;
      nonempty <= (count_next != '0);
    end
  end

endmodule

// File: rtl/iob_2p_mem_rd_stream.sv
// Burst read engine: walks len addresses from base_addr on the RAM read port and streams the words out.
// Reads are credit-limited by buffer occupancy plus the in-flight read, so m_ready never reaches the RAM.
module iob_2p_mem_rd_stream
  import iob_2p_mem_rd_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_r_addr,
  output logic              mem_r_port_en,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  state_t              state;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     issued;
  logic [ADDR_W:0]     accepted;
  logic                inflight;
  logic                busy_q;
  logic                done_q;
  logic                buf_empty;
  logic [CREDIT_W-1:0] buf_count;
  logic [CREDIT_W:0]   outstanding;
  logic                issue;
  logic                pop;

  // Issue decision uses registered state only: occupancy plus the in-flight read must leave room.
  assign outstanding   = {1'b0, buf_count} + {{CREDIT_W{1'b0}}, inflight};
  assign issue         = (state == RUN) && (issued < len_q) &&
                         (outstanding < (CREDIT_W+1)'(RD_BUF_DEPTH));
  assign mem_r_port_en = issue;
  assign mem_r_addr    = base_q + issued[ADDR_W-1:0];
  assign m_valid       = ~buf_empty;
  assign pop           = m_valid & m_ready;
  assign busy          = busy_q;
  assign done          = done_q;

  iob_2p_mem_rd_buf #(.DATA_W(DATA_W)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .pop   (pop),
    .din   (mem_data_out),
    .dout  (m_data),
    .empty (buf_empty),
    .count (buf_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      accepted <= '0;
      inflight <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      inflight <= issue;
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            base_q   <= base_addr;
            len_q    <= len;
            issued   <= '0;
            accepted <= '0;
            busy_q   <= 1'b1;
            state    <= (len != '0) ? RUN : DONE;
            done_q   <= (len == '0);
          end
        end
        RUN: begin
          if (issue) issued <= issued + ONE;
          if (pop) begin
            accepted <= accepted + ONE;
            if (accepted + ONE == len_q) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iob_2p_mem_rd_stream.sv
// Directed bench for iob_2p_mem_rd_stream with a registered-read RAM model.
// The RAM model drives X on the data port except in the cycle after a read.
module tb_iob_2p_mem_rd_stream;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] base_addr;
  logic [6:0] len;
  logic       busy;
  logic       done;
  logic [5:0] mem_r_addr;
  logic       mem_r_port_en;
  logic [7:0] mem_data_out;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  logic [7:0] ram [64];
  logic [7:0] rd_q;
  logic       rd_vld;

  int checks;
  int fails;

  logic [7:0] got_data [$];
  logic [5:0] got_addr [$];
  int first_valid, last_xfer, done_cyc, done_cnt, max_out, en_violation, hold_en;

  iob_2p_mem_rd_stream #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .len           (len),
    .busy          (busy),
    .done          (done),
    .mem_r_addr    (mem_r_addr),
    .mem_r_port_en (mem_r_port_en),
    .mem_data_out  (mem_data_out),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_vld <= mem_r_port_en;
    rd_q   <= ram[mem_r_addr];
  end
  assign mem_data_out = rd_vld ? rd_q : 8'hxx;

  // Runs one burst; mode 0 keeps m_ready high, mode 1 holds it low for k=2..9 then toggles it.
  task automatic run_burst(input logic [5:0] b, input logic [6:0] l, input int mode, input int restart_k);
    int issued_n;
    int acc_n;
    int out_before;
    issued_n = 0; acc_n = 0;
    got_data.delete(); got_addr.delete();
    first_valid = -1; last_xfer = -1; done_cyc = -1; done_cnt = 0;
    max_out = 0; en_violation = 0; hold_en = 0;
    base_addr = b; len = l; start = 1'b1; m_ready = (mode == 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (mode == 0) m_ready = 1'b1;
      else if (k >= 2 && k <= 9) m_ready = 1'b0;
      else m_ready = ((k * 5 + 1) % 3) != 0;
      if (k == restart_k) begin
        start = 1'b1; base_addr = b + 6'd9; len = 7'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      out_before = issued_n - acc_n;
      if (mem_r_port_en) begin
        if (out_before >= 3) en_violation++;
        if (mode == 1 && k >= 3 && k <= 9) hold_en++;
        got_addr.push_back(mem_r_addr);
        issued_n++;
      end
      if (issued_n - acc_n > max_out) max_out = issued_n - acc_n;
      if (m_valid && first_valid < 0) first_valid = k;
      if (m_valid && m_ready) begin
        got_data.push_back(m_data);
        acc_n++;
        last_xfer = k + 1;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      @(posedge clk); #1;
      if (done_cyc >= 0 && k >= done_cyc + 2) break;
    end
    start = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (mem_r_port_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_port_en: got %b expected 0", mem_r_port_en); end
    checks++; if (mem_r_addr !== 6'd0) begin fails++; $display("[TB] FAIL reset_addr: got %0d expected 0", mem_r_addr); end
    checks++; if (m_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_m_data: got %0h expected 0", m_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_burst();
    logic [7:0] g;
    run_burst(6'd4, 7'd5, 0, -1);
    checks++; if (got_data.size() != 5) begin fails++; $display("[TB] FAIL basic_count: got %0d expected 5", got_data.size()); end
    for (int i = 0; i < 5; i++) begin
      g = (i < got_data.size()) ? got_data[i] : 8'hxx;
      checks++; if (g !== 8'(8'h14 + i)) begin fails++; $display("[TB] FAIL basic_data[%0d]: got %0h expected %0h", i, g, 8'(8'h14 + i)); end
      checks++; if (i >= got_addr.size() || got_addr[i] !== 6'(4 + i)) begin fails++; $display("[TB] FAIL basic_addr[%0d]: expected %0d", i, 4 + i); end
    end
    checks++; if (first_valid != 2) begin fails++; $display("[TB] FAIL basic_latency: got %0d expected 2", first_valid); end
    checks++; if (done_cyc != last_xfer || done_cyc < 0) begin fails++; $display("[TB] FAIL basic_done_time: got %0d expected %0d", done_cyc, last_xfer); end
    checks++; if (done_cnt != 1) begin fails++; $display("[TB] FAIL basic_done_pulse: got %0d expected 1", done_cnt); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_wrap();
    logic [5:0] exp_addr [4];
    logic [7:0] g;
    exp_addr[0] = 6'd62; exp_addr[1] = 6'd63; exp_addr[2] = 6'd0; exp_addr[3] = 6'd1;
    run_burst(6'd62, 7'd4, 0, -1);
    checks++; if (got_addr.size() != 4) begin fails++; $display("[TB] FAIL wrap_reads: got %0d expected 4", got_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (i >= got_addr.size() || got_addr[i] !== exp_addr[i]) begin fails++; $display("[TB] FAIL wrap_addr[%0d]: expected %0d", i, exp_addr[i]); end
      g = (i < got_data.size()) ? got_data[i] : 8'hxx;
      checks++; if (g !== ram[exp_addr[i]]) begin fails++; $display("[TB] FAIL wrap_data[%0d]: got %0h expected %0h", i, g, ram[exp_addr[i]]); end
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] g;
    run_burst(6'd20, 7'd10, 1, -1);
    checks++; if (got_data.size() != 10) begin fails++; $display("[TB] FAIL bp_count: got %0d expected 10", got_data.size()); end
    for (int i = 0; i < 10; i++) begin
      g = (i < got_data.size()) ? got_data[i] : 8'hxx;
      checks++; if (g !== ram[20 + i]) begin fails++; $display("[TB] FAIL bp_data[%0d]: got %0h expected %0h", i, g, ram[20 + i]); end
    end
    checks++; if (max_out != 3) begin fails++; $display("[TB] FAIL bp_max_outstanding: got %0d expected 3", max_out); end
    checks++; if (en_violation != 0) begin fails++; $display("[TB] FAIL bp_credit: got %0d reads over credit expected 0", en_violation); end
    checks++; if (hold_en != 0) begin fails++; $display("[TB] FAIL bp_hold_low_reads: got %0d expected 0", hold_en); end
    checks++; if (done_cnt != 1) begin fails++; $display("[TB] FAIL bp_done_pulse: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_len_zero();
    run_burst(6'd7, 7'd0, 0, -1);
    checks++; if (done_cyc != 0) begin fails++; $display("[TB] FAIL len0_done_time: got %0d expected 0", done_cyc); end
    checks++; if (got_addr.size() != 0) begin fails++; $display("[TB] FAIL len0_reads: got %0d expected 0", got_addr.size()); end
    checks++; if (first_valid != -1) begin fails++; $display("[TB] FAIL len0_m_valid: got %0d expected -1", first_valid); end
    checks++; if (done_cnt != 1) begin fails++; $display("[TB] FAIL len0_done_pulse: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_len_max();
    int bad;
    bad = 0;
    run_burst(6'd0, 7'd64, 0, -1);
    checks++; if (got_data.size() != 64) begin fails++; $display("[TB] FAIL len64_count: got %0d expected 64", got_data.size()); end
    for (int i = 0; i < 64 && i < got_data.size(); i++)
      if (got_data[i] !== ram[i]) bad++;
    checks++; if (bad != 0) begin fails++; $display("[TB] FAIL len64_data: got %0d bad words expected 0", bad); end
    checks++; if (done_cyc != last_xfer || done_cnt != 1) begin fails++; $display("[TB] FAIL len64_done: got cycle %0d count %0d expected cycle %0d count 1", done_cyc, done_cnt, last_xfer); end
  endtask

  task automatic test_start_ignored();
    logic [7:0] g;
    run_burst(6'd30, 7'd6, 0, 3);
    checks++; if (got_addr.size() != 6) begin fails++; $display("[TB] FAIL restart_reads: got %0d expected 6", got_addr.size()); end
    for (int i = 0; i < 6; i++) begin
      g = (i < got_data.size()) ? got_data[i] : 8'hxx;
      checks++; if (g !== ram[30 + i]) begin fails++; $display("[TB] FAIL restart_data[%0d]: got %0h expected %0h", i, g, ram[30 + i]); end
    end
    checks++; if (done_cnt != 1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL restart_done: got count %0d busy %b expected 1 and 0", done_cnt, busy); end
  endtask

  task automatic test_reset_mid_burst();
    int done_seen;
    logic [7:0] g;
    done_seen = 0;
    base_addr = 6'd0; len = 7'd20; start = 1'b1; m_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++; if (m_valid !== 1'b1) begin fails++; $display("[TB] FAIL midrst_pre_valid: got %b expected 1", m_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (m_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_data !== 8'h00) begin fails++; $display("[TB] FAIL midrst_m_data: got %0h expected 0", m_data); end
    checks++; if (mem_r_port_en !== 1'b0 || mem_r_addr !== 6'd0) begin fails++; $display("[TB] FAIL midrst_read_port: got en %b addr %0d expected 0 0", mem_r_port_en, mem_r_addr); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done || m_valid) done_seen++;
    end
    checks++; if (done_seen != 0) begin fails++; $display("[TB] FAIL midrst_no_done: got %0d stray cycles expected 0", done_seen); end
    @(posedge clk); #1;
    run_burst(6'd10, 7'd3, 0, -1);
    checks++; if (got_data.size() != 3) begin fails++; $display("[TB] FAIL midrst_after_count: got %0d expected 3", got_data.size()); end
    for (int i = 0; i < 3; i++) begin
      g = (i < got_data.size()) ? got_data[i] : 8'hxx;
      checks++; if (g !== ram[10 + i]) begin fails++; $display("[TB] FAIL midrst_after_data[%0d]: got %0h expected %0h", i, g, ram[10 + i]); end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    for (int i = 0; i < 64; i++) ram[i] = 8'(i + 16);
    test_reset();
    test_basic_burst();
    test_wrap();
    test_back_pressure();
    test_len_zero();
    test_len_max();
    test_start_ignored();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
